// File: rtl/uart_bus_arbiter.sv
// Two-port round-robin arbiter and setup/strobe/hold bus-cycle sequencer
// for the UART core register bus.
module uart_bus_arbiter #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req_i,
  input  logic       m0_we_i,
  input  logic [3:0] m0_addr_i,
  input  logic [7:0] m0_wdata_i,
  output logic       m0_ack_o,
  output logic [7:0] m0_rdata_o,
  input  logic       m1_req_i,
  input  logic       m1_we_i,
  input  logic [3:0] m1_addr_i,
  input  logic [7:0] m1_wdata_i,
  output logic       m1_ack_o,
  output logic [7:0] m1_rdata_o,
  output logic [3:0] AddrBus_o,
  output logic       n_ChipSelect_o,
  output logic       n_rd_o,
  output logic       n_we_o,
  output logic [7:0] DataBus_o,
  input  logic [7:0] DataBus_i,
  output logic       busy_o,
  output logic       owner_o
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       we_q, we_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;
  logic       ack0_q, ack0_d, ack1_q, ack1_d;
  logic [7:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic       cs_n_q, cs_n_d, rd_n_q, rd_n_d, we_n_q, we_n_d;
  logic [3:0] abus_q, abus_d;
  logic [7:0] dbus_q, dbus_d;
  logic       elig0, elig1, grant;

  // A port being acked this cycle is not eligible, so the other port wins the gap cycle.
  assign elig0 = m0_req_i & ~ack0_q;
  assign elig1 = m1_req_i & ~ack1_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    grant        = 1'b0;
    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          grant        = (elig0 & elig1) ? ~last_owner_q : elig1;
          owner_d      = grant;
          last_owner_d = grant;
          we_d         = grant ? m1_we_i    : m0_we_i;
          addr_d       = grant ? m1_addr_i  : m0_addr_i;
          wdata_d      = grant ? m1_wdata_i : m0_wdata_i;
          cnt_d        = SETUP_LD;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = STROBE_LD;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (owner_q) rdata1_d = DataBus_i;
            else         rdata0_d = DataBus_i;
          end
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus pins are registered, so they are derived from the next state.
    cs_n_d = (state_d == IDLE);
    abus_d = (state_d == IDLE) ? 4'h0 : addr_d;
    dbus_d = ((state_d != IDLE) && we_d) ? wdata_d : 8'h00;
    we_n_d = ~((state_d == STROBE) && we_d);
    rd_n_d = ~((state_d == STROBE) && !we_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 4'h0;
      wdata_q      <= 8'h00;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= 8'h00;
      rdata1_q     <= 8'h00;
      cs_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      abus_q       <= 4'h0;
      dbus_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      cs_n_q       <= cs_n_d;
      rd_n_q       <= rd_n_d;
      we_n_q       <= we_n_d;
      abus_q       <= abus_d;
      dbus_q       <= dbus_d;
    end
  end

  assign m0_ack_o       = ack0_q;
  assign m1_ack_o       = ack1_q;
  assign m0_rdata_o     = rdata0_q;
  assign m1_rdata_o     = rdata1_q;
  assign AddrBus_o      = abus_q;
  assign n_ChipSelect_o = cs_n_q;
  assign n_rd_o         = rd_n_q;
  assign n_we_o         = we_n_q;
  assign DataBus_o      = dbus_q;
  assign busy_o         = (state_q != IDLE);
  assign owner_o        = owner_q;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Bench for uart_bus_arbiter: default-timing instance (a_*) and a stretched
// 2/4/3 instance (b_*), checked cycle by cycle against queued expectations.
module tb_uart_bus_arbiter;
  localparam int BW = 49;
  localparam int AW = 25;

  logic clk;
  logic rst;
  int   cyc = 0;
  logic end_req;

  // Handshake: req is a level held until the one-cycle ack; the command is
  // taken on the grant edge, so the bench may change or drop it afterwards.
  logic       a_m0_req, a_m0_we, a_m1_req, a_m1_we;
  logic [3:0] a_m0_addr, a_m1_addr, a_abus;
  logic [7:0] a_m0_wdata, a_m1_wdata, a_m0_rdata, a_m1_rdata, a_dout, a_din;
  logic       a_m0_ack, a_m1_ack, a_cs_n, a_rd_n, a_we_n, a_busy, a_owner;

  logic       b_m0_req, b_m0_we, b_m1_req, b_m1_we;
  logic [3:0] b_m0_addr, b_m1_addr, b_abus;
  logic [7:0] b_m0_wdata, b_m1_wdata, b_m0_rdata, b_m1_rdata, b_dout, b_din;
  logic       b_m0_ack, b_m1_ack, b_cs_n, b_rd_n, b_we_n, b_busy, b_owner;

  logic [BW-1:0] bus_a_q[$], bus_b_q[$];
  logic [AW-1:0] ack_a_q[$], ack_b_q[$];
  logic [7:0]    mr [2][2];
  int n_checks = 0;
  int n_pass   = 0;

  uart_bus_arbiter dut_a (
    .clk(clk), .rst(rst),
    .m0_req_i(a_m0_req), .m0_we_i(a_m0_we), .m0_addr_i(a_m0_addr), .m0_wdata_i(a_m0_wdata),
    .m0_ack_o(a_m0_ack), .m0_rdata_o(a_m0_rdata),
    .m1_req_i(a_m1_req), .m1_we_i(a_m1_we), .m1_addr_i(a_m1_addr), .m1_wdata_i(a_m1_wdata),
    .m1_ack_o(a_m1_ack), .m1_rdata_o(a_m1_rdata),
    .AddrBus_o(a_abus), .n_ChipSelect_o(a_cs_n), .n_rd_o(a_rd_n), .n_we_o(a_we_n),
    .DataBus_o(a_dout), .DataBus_i(a_din), .busy_o(a_busy), .owner_o(a_owner)
  );

  uart_bus_arbiter #(.SETUP_CYC(2), .STROBE_CYC(4), .HOLD_CYC(3)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req_i(b_m0_req), .m0_we_i(b_m0_we), .m0_addr_i(b_m0_addr), .m0_wdata_i(b_m0_wdata),
    .m0_ack_o(b_m0_ack), .m0_rdata_o(b_m0_rdata),
    .m1_req_i(b_m1_req), .m1_we_i(b_m1_we), .m1_addr_i(b_m1_addr), .m1_wdata_i(b_m1_wdata),
    .m1_ack_o(b_m1_ack), .m1_rdata_o(b_m1_rdata),
    .AddrBus_o(b_abus), .n_ChipSelect_o(b_cs_n), .n_rd_o(b_rd_n), .n_we_o(b_we_n),
    .DataBus_o(b_dout), .DataBus_i(b_din), .busy_o(b_busy), .owner_o(b_owner)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- expectation builders ----------------
  function automatic logic [BW-1:0] mk(input int t, input logic busy, input logic owner,
                                       input logic cs, input logic rd, input logic we,
                                       input logic [3:0] a, input logic [7:0] d,
                                       input logic [7:0] r0, input logic [7:0] r1);
    logic [15:0] ts;
    ts = t[15:0];
    return {ts, busy, owner, cs, rd, we, a, d, r0, r1};
  endfunction

  task automatic push_bus(input logic sel, input logic [BW-1:0] v);
    if (sel) bus_b_q.push_back(v);
    else     bus_a_q.push_back(v);
  endtask

  task automatic push_idle(input logic sel, input int t, input logic owner);
    push_bus(sel, mk(t, 1'b0, owner, 1'b1, 1'b1, 1'b1, 4'h0, 8'h00, mr[sel][0], mr[sel][1]));
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < 2; p++) mr[s][p] = 8'h00;
  endtask

  // One access granted at the end of cycle t0: expectations for t0+1 .. ack cycle.
  task automatic push_txn(input logic sel, input int t0, input logic port, input logic we,
                          input logic [3:0] a, input logic [7:0] wd, input logic [7:0] rv,
                          input int s, input int st, input int h);
    int n;
    logic strb;
    logic [15:0] ts;
    logic [AW-1:0] ae;
    n = s + st + h;
    for (int k = 1; k <= n + 1; k++) begin
      strb = (k > s) && (k <= s + st);
      if (!we && k == s + st + 1) mr[sel][port] = rv;
      if (k <= n)
        push_bus(sel, mk(t0 + k, 1'b1, port, 1'b0, !(strb && !we), !(strb && we), a,
                         we ? wd : 8'h00, mr[sel][0], mr[sel][1]));
      else
        push_idle(sel, t0 + k, port);
    end
    ts = 16'(t0 + n + 1);
    ae = {ts, port, mr[sel][port]};
    if (sel) ack_b_q.push_back(ae);
    else     ack_a_q.push_back(ae);
  endtask

  // ---------------- driver helpers ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) next_cyc();
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    logic [BW-1:0] eb;
    logic [AW-1:0] ea, aa;
    if (bus_a_q.size() > 0 && bus_a_q[0][BW-1 -: 16] == 16'(cyc)) begin
      eb = bus_a_q.pop_front();
      chk("bus_a", mk(cyc, a_busy, a_owner, a_cs_n, a_rd_n, a_we_n, a_abus, a_dout,
                      a_m0_rdata, a_m1_rdata), eb);
    end
    if (bus_b_q.size() > 0 && bus_b_q[0][BW-1 -: 16] == 16'(cyc)) begin
      eb = bus_b_q.pop_front();
      chk("bus_b", mk(cyc, b_busy, b_owner, b_cs_n, b_rd_n, b_we_n, b_abus, b_dout,
                      b_m0_rdata, b_m1_rdata), eb);
    end
    if (a_m0_ack || a_m1_ack) begin
      ea = (ack_a_q.size() > 0) ? ack_a_q.pop_front() : '1;
      aa = {16'(cyc), a_m1_ack, a_m1_ack ? a_m1_rdata : a_m0_rdata};
      if (a_m0_ack && a_m1_ack) aa = '0;
      chk("ack_a", aa, ea);
    end
    if (b_m0_ack || b_m1_ack) begin
      ea = (ack_b_q.size() > 0) ? ack_b_q.pop_front() : '1;
      aa = {16'(cyc), b_m1_ack, b_m1_ack ? b_m1_rdata : b_m0_rdata};
      if (b_m0_ack && b_m1_ack) aa = '0;
      chk("ack_b", aa, ea);
    end
    if (end_req) begin
      chk("ack_a_missing", ack_a_q.size(), 0);
      chk("ack_b_missing", ack_b_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0, t1;
    rst = 1'b0; end_req = 1'b0;
    a_m0_req = 0; a_m0_we = 0; a_m0_addr = 0; a_m0_wdata = 0;
    a_m1_req = 0; a_m1_we = 0; a_m1_addr = 0; a_m1_wdata = 0; a_din = 8'hEE;
    b_m0_req = 0; b_m0_we = 0; b_m0_addr = 0; b_m0_wdata = 0;
    b_m1_req = 0; b_m1_we = 0; b_m1_addr = 0; b_m1_wdata = 0; b_din = 8'hFF;
    model_reset();
    next_cyc(); next_cyc();
    push_idle(1'b0, cyc, 1'b0);
    push_idle(1'b1, cyc, 1'b0);
    next_cyc();
    rst = 1'b1;
    push_idle(1'b0, cyc, 1'b0);
    push_idle(1'b1, cyc, 1'b0);
    next_cyc();

    // m0 write 0x5A to 0x3; command scrambled and req dropped mid-access
    t0 = cyc;
    a_m0_req = 1; a_m0_we = 1; a_m0_addr = 4'h3; a_m0_wdata = 8'h5A;
    push_txn(1'b0, t0, 1'b0, 1'b1, 4'h3, 8'h5A, 8'h00, 1, 2, 1);
    wait_until(t0 + 2);
    a_m0_req = 0; a_m0_we = 0; a_m0_addr = 4'hF; a_m0_wdata = 8'hFF;
    wait_until(t0 + 6);

    // m1 read of 0x7; only the last strobe cycle carries 0xA5
    t0 = cyc;
    a_m1_req = 1; a_m1_we = 0; a_m1_addr = 4'h7; a_m1_wdata = 8'h99;
    push_txn(1'b0, t0, 1'b1, 1'b0, 4'h7, 8'h00, 8'hA5, 1, 2, 1);
    wait_until(t0 + 2);
    a_din = 8'h11; next_cyc();
    a_din = 8'hA5; next_cyc();
    a_din = 8'hEE;
    wait_until(t0 + 5);
    a_m1_req = 0;
    next_cyc();

    // contention straight out of reset: m0 first, m1 in the ack cycle
    rst = 1'b0; model_reset();
    push_idle(1'b0, cyc, 1'b0);
    next_cyc();
    rst = 1'b1;
    push_idle(1'b0, cyc, 1'b0);
    next_cyc();
    t0 = cyc;
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 4'h2;
    a_m1_req = 1; a_m1_we = 1; a_m1_addr = 4'hD; a_m1_wdata = 8'hC3;
    a_din = 8'h5C;
    push_txn(1'b0, t0,     1'b0, 1'b0, 4'h2, 8'h00, 8'h5C, 1, 2, 1);
    push_txn(1'b0, t0 + 5, 1'b1, 1'b1, 4'hD, 8'hC3, 8'h00, 1, 2, 1);
    wait_until(t0 + 5);
    a_m0_req = 0; a_din = 8'hEE;
    wait_until(t0 + 10);
    a_m1_req = 0;
    next_cyc();

    // m0 held high, m1 re-requesting: grants alternate m0,m1,m0,m1,m0
    t0 = cyc;
    a_m0_req = 1; a_m0_we = 1; a_m0_addr = 4'h4; a_m0_wdata = 8'h40;
    a_m1_req = 1; a_m1_we = 0; a_m1_addr = 4'h8; a_din = 8'h77;
    push_txn(1'b0, t0,      1'b0, 1'b1, 4'h4, 8'h40, 8'h00, 1, 2, 1);
    push_txn(1'b0, t0 + 5,  1'b1, 1'b0, 4'h8, 8'h00, 8'h77, 1, 2, 1);
    push_txn(1'b0, t0 + 10, 1'b0, 1'b1, 4'h4, 8'h40, 8'h00, 1, 2, 1);
    push_txn(1'b0, t0 + 15, 1'b1, 1'b0, 4'h8, 8'h00, 8'h88, 1, 2, 1);
    push_txn(1'b0, t0 + 20, 1'b0, 1'b1, 4'h4, 8'h40, 8'h00, 1, 2, 1);
    wait_until(t0 + 10);
    a_m1_req = 0;
    next_cyc();
    a_m1_req = 1; a_din = 8'h88;
    wait_until(t0 + 20);
    a_m1_req = 0;
    wait_until(t0 + 25);
    a_m0_req = 0; a_din = 8'hEE;
    next_cyc();

    // reset during the write strobe, then a reissued write
    t0 = cyc;
    a_m0_req = 1; a_m0_we = 1; a_m0_addr = 4'h9; a_m0_wdata = 8'h96;
    push_bus(1'b0, mk(t0 + 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 8'h96, mr[0][0], mr[0][1]));
    push_bus(1'b0, mk(t0 + 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h9, 8'h96, mr[0][0], mr[0][1]));
    wait_until(t0 + 3);
    #1;
    rst = 1'b0; a_m0_req = 0; model_reset();
    push_idle(1'b0, t0 + 3, 1'b0);
    next_cyc();
    push_idle(1'b0, cyc, 1'b0);
    rst = 1'b1;
    next_cyc();
    t1 = cyc;
    a_m0_req = 1;
    push_txn(1'b0, t1, 1'b0, 1'b1, 4'h9, 8'h96, 8'h00, 1, 2, 1);
    wait_until(t1 + 5);
    a_m0_req = 0;
    next_cyc();

    // stretched timing: 2 setup, 4 strobe, 3 hold read
    t0 = cyc;
    b_m0_req = 1; b_m0_we = 0; b_m0_addr = 4'hC;
    push_txn(1'b1, t0, 1'b0, 1'b0, 4'hC, 8'h00, 8'h3C, 2, 4, 3);
    wait_until(t0 + 5);
    b_din = 8'h42; next_cyc();
    b_din = 8'h3C; next_cyc();
    b_din = 8'hFF;
    wait_until(t0 + 10);
    b_m0_req = 0;
    next_cyc(); next_cyc();
    end_req = 1'b1;
  end

endmodule

// File: doc/uart_bus_arbiter.md
# uart_bus_arbiter

Two-port arbiter and bus-cycle sequencer for the UART core's register bus (AddrBus/n_ChipSelect/n_rd/n_we/DataBus). It sits between the UART core and two independent requesters, for example a host CPU bridge (port 0) and an autonomous frame/poll engine (port 1). It grants the bus round-robin and generates the setup, strobe and hold phases of each access. Read data is returned with a one-cycle acknowledge.

## Interface
Parameters:
- SETUP_CYC, 1, cycles CS/address are valid before the strobe; legal range 1..15.
- STROBE_CYC, 2, cycles n_rd/n_we are held low; legal range 1..15.
- HOLD_CYC, 1, cycles CS/address/write data are held after the strobe; legal range 1..15.

Ports:
- clk  in  1  system clock; one clock domain only.
- rst  in  1  reset, asynchronous, active-low.
- m0_req_i / m1_req_i  in  1  access request; level, held until ack.
- m0_we_i / m1_we_i  in  1  1 = write, 0 = read.
- m0_addr_i / m1_addr_i  in  4  register address.
- m0_wdata_i / m1_wdata_i  in  8  write data.
- m0_ack_o / m1_ack_o  out  1  one-cycle completion pulse.
- m0_rdata_o / m1_rdata_o  out  8  read data; held until that port's next read ack.
- AddrBus_o  out  4  address to the UART core.
- n_ChipSelect_o  out  1  chip select, active-low.
- n_rd_o  out  1  read strobe, active-low.
- n_we_o  out  1  write strobe, active-low.
- DataBus_o  out  8  write data to the UART core.
- DataBus_i  in  8  read data from the UART core.
- busy_o  out  1  high while state is not IDLE.
- owner_o  out  1  port currently or most recently granted.

## Operation
- FSM states and transitions:
  - IDLE: if any eligible request exists, grant, latch we/addr/wdata, then go to SETUP.
  - SETUP runs for SETUP_CYC cycles, then STROBE.
  - STROBE runs for STROBE_CYC cycles, then HOLD.
  - HOLD runs for HOLD_CYC cycles, then IDLE.
- Phase length uses one shared 4-bit down-counter, loaded with N-1 on phase entry. The phase exits when the counter reads 0.
- Eligibility: a port whose ack_o is high in the current cycle is masked from arbitration in that cycle.
- Arbitration rules:
  - Only one eligible request: that port is granted.
  - Both eligible: grant the port not equal to last_owner.
  - last_owner updates on every grant.
- Bus outputs are all registered:
  - IDLE: CS = 1, n_rd = 1, n_we = 1, AddrBus = 0, DataBus_o = 0.
  - SETUP/STROBE/HOLD: CS = 0 and AddrBus = latched address.
  - Write: DataBus_o = latched wdata in SETUP/STROBE/HOLD; n_we = 0 in STROBE only.
  - Read: DataBus_o = 0; n_rd = 0 in STROBE only.
- Read capture: DataBus_i is sampled on the clock edge that ends the final STROBE cycle and stored into the owner's rdata register.
- ack: the owner's ack_o pulses high for exactly one cycle, namely the first cycle back in IDLE. The other port's ack stays 0.
- A requester dropping req mid-transaction does not abort it. The access completes and the ack is still pulsed.
- Changing command inputs after grant has no effect, because the command was latched at grant.

## Timing
- Reset values: state IDLE, CS = 1, n_rd = 1, n_we = 1, AddrBus_o = 0, DataBus_o = 0, both ack = 0, both rdata = 0x00, busy_o = 0, owner_o = 0, last_owner = 1 (so port 0 wins the first contention).
- Latency: with req sampled high in IDLE at cycle 0, ack is high in cycle 1+SETUP_CYC+STROBE_CYC+HOLD_CYC. With defaults that is cycle 5.
  - CS is low in cycles 1..4.
  - Strobe is low in cycles 2..3.
- Back-to-back: the minimum gap between transactions is one IDLE cycle (the ack cycle). If another port is eligible in the ack cycle, it is granted in that cycle. CS therefore returns high for exactly 1 cycle between accesses.
- A requester keeping req high through its ack cycle is treated as making a new request from the following cycle.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously). No ack is issued and the access is lost; requesters must reissue.
- owner_o changes in the cycle after the grant edge, together with CS falling.

## Test plan
- m0 write, addr 0x3, data 0x5A, defaults: AddrBus = 3 and DataBus_o = 0x5A for cycles 1..4, n_we low in cycles 2..3, m0_ack in cycle 5 only, m1_ack stays 0.
- m1 read, addr 0x7, DataBus_i = 0xA5 during STROBE: n_rd low in cycles 2..3, m1_rdata = 0xA5 at ack in cycle 5, m0_rdata still 0x00.
- m0 and m1 both request at cycle 0 out of reset: m0 is acked at cycle 5, m1 is granted in cycle 5 and acked at cycle 10, CS is high only in cycle 5.
- m0 req held continuously, m1 requesting repeatedly: grants alternate m0, m1, m0, m1; neither port gets two consecutive grants while the other is waiting.
- rst driven low during STROBE of a write: n_we, CS and DataBus_o go idle immediately with no ack; after release, a reissued request completes with normal 5-cycle latency.
- SETUP_CYC = 2, STROBE_CYC = 4, HOLD_CYC = 3, read: CS low in cycles 1..9, n_rd low in cycles 3..6, rdata sampled at the end of cycle 6, ack in cycle 10.
